// File: rtl/rtot_packer.sv
// rtl/rtot_packer.sv - nibble-to-word packer with flush and a small output FIFO
module rtot_packer #(
  parameter int NIB_W = 4,
  parameter int NIBS  = 3,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [NIB_W-1:0]      in_nib,
  input  logic                  flush,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [NIBS*NIB_W-1:0] out_word,
  output logic [1:0]            out_cnt,
  input  logic                  out_ready,
  output logic [15:0]           word_cnt
);
  localparam int WORD_W = NIBS * NIB_W;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef enum logic {IDLE = 1'b0, PART = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [1:0]        idx, idx_nxt;
  logic [WORD_W-1:0] asm_q, asm_nxt, asm_with;
  logic              accept, do_flush, pop;
  logic              push;
  logic [WORD_W-1:0] push_word;
  logic [1:0]        push_cnt;
  int                pos;

  logic [WORD_W-1:0] mem_word [DEPTH];
  logic [1:0]        mem_cnt  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      asm_q <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      asm_q <= asm_nxt;
    end
  end

  // A nibble landing in the same cycle as a flush is merged before the word is closed.
  always_comb begin
    accept    = in_valid && in_ready;
    do_flush  = flush && in_ready;
    pos       = (NIBS - 1 - int'(idx)) * NIB_W;
    asm_with  = asm_q;
    if (accept) asm_with[pos +: NIB_W] = in_nib;
    state_nxt = state;
    idx_nxt   = idx;
    asm_nxt   = asm_q;
    push      = 1'b0;
    push_word = asm_with;
    push_cnt  = '0;
    if (accept && idx == 2'(NIBS - 1)) begin
      push      = 1'b1;
      push_cnt  = 2'(NIBS);
      idx_nxt   = '0;
      asm_nxt   = '0;
      state_nxt = IDLE;
    end else if (accept && do_flush) begin
      push      = 1'b1;
      push_cnt  = idx + 2'd1;
      idx_nxt   = '0;
      asm_nxt   = '0;
      state_nxt = IDLE;
    end else if (accept) begin
      idx_nxt   = idx + 2'd1;
      asm_nxt   = asm_with;
      state_nxt = PART;
    end else if (do_flush && state == PART) begin
      push      = 1'b1;
      push_cnt  = idx;
      idx_nxt   = '0;
      asm_nxt   = '0;
      state_nxt = IDLE;
    end
  end

  always_comb begin
    in_ready  = rst_n && (fifo_count < CNT_W'(DEPTH));
    out_valid = (fifo_count != '0);
    pop       = out_valid && out_ready;
    out_word  = out_valid ? mem_word[rd_ptr] : '0;
    out_cnt   = out_valid ? mem_cnt[rd_ptr] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      word_cnt   <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) begin
        rd_ptr   <= ptr_inc(rd_ptr);
        word_cnt <= word_cnt + 16'd1;
      end
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (!push && pop) fifo_count <= fifo_count - 1'b1;
    end
  end

  // Pushes need in_ready, so storage never sees a write during reset or when full.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_word[wr_ptr] <= push_word;
      mem_cnt[wr_ptr]  <= push_cnt;
    end
  end
endmodule

// File: tb/tb_rtot_packer.sv
// tb/tb_rtot_packer.sv - randomized and directed bench for rtot_packer against a queue model
module tb_rtot_packer;
  localparam int NIB_W = 4;
  localparam int NIBS  = 3;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_nib = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [11:0] out_word;
  logic [1:0]  out_cnt;
  logic [15:0] word_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  logic [3:0]  pend  [$];
  logic [11:0] qword [$];
  logic [1:0]  qcnt  [$];
  logic [15:0] m_wcnt = '0;

  always #5 clk = ~clk;

  rtot_packer #(.NIB_W(NIB_W), .NIBS(NIBS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_nib(in_nib), .flush(flush),
    .in_ready(in_ready), .out_valid(out_valid), .out_word(out_word), .out_cnt(out_cnt),
    .out_ready(out_ready), .word_cnt(word_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: nibbles collect in a list; a full list or a flush closes a word into a queue.
  always @(posedge clk) begin
    bit          rdy;
    logic [11:0] w;
    if (!rst_n) begin
      pend.delete();
      qword.delete();
      qcnt.delete();
      m_wcnt = '0;
    end else begin
      rdy = (qword.size() < DEPTH);
      if (qword.size() > 0 && out_ready) begin
        void'(qword.pop_front());
        void'(qcnt.pop_front());
        m_wcnt = m_wcnt + 16'd1;
      end
      if (rdy && in_valid) pend.push_back(in_nib);
      if (pend.size() == NIBS || (rdy && flush && pend.size() > 0)) begin
        w = '0;
        for (int i = 0; i < pend.size(); i++) w = w | (12'(pend[i]) << ((NIBS - 1 - i) * NIB_W));
        qword.push_back(w);
        qcnt.push_back(2'(pend.size()));
        pend.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 32'(in_ready), 32'(rst_n && (qword.size() < DEPTH)));
      check("out_valid", 32'(out_valid), 32'(qword.size() > 0));
      check("out_word", 32'(out_word), (qword.size() > 0) ? 32'(qword[0]) : 32'd0);
      check("out_cnt", 32'(out_cnt), (qcnt.size() > 0) ? 32'(qcnt[0]) : 32'd0);
      check("word_cnt", 32'(word_cnt), 32'(m_wcnt));
    end
  end

  task automatic cyc(input bit v, input logic [3:0] n, input bit f, input bit r);
    in_valid = v; in_nib = n; flush = f; out_ready = r;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(0, 4'h0, 0, 0);
    cyc(0, 4'h0, 0, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    int acc;
    int nxt;

    // reset held three cycles with traffic present
    cyc(1, 4'h5, 1, 1);
    chk_en = 1'b1;
    cyc(1, 4'h5, 1, 1);
    cyc(1, 4'h5, 1, 1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_word", 32'(out_word), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);

    // full word
    cyc(1, 4'hA, 0, 1);
    cyc(1, 4'h5, 0, 1);
    check("full_not_yet", 32'(out_valid), 32'd0);
    cyc(1, 4'hC, 0, 1);
    check("full_valid", 32'(out_valid), 32'd1);
    check("full_word", 32'(out_word), 32'h0A5C);
    check("full_cnt", 32'(out_cnt), 32'd3);
    cyc(0, 4'h0, 0, 1);
    check("full_word_cnt", 32'(word_cnt), 32'd1);

    // partial flush, then flush in idle
    cyc(1, 4'h3, 0, 1);
    cyc(1, 4'h9, 0, 1);
    cyc(0, 4'h0, 1, 0);
    check("pflush_word", 32'(out_word), 32'h0390);
    check("pflush_cnt", 32'(out_cnt), 32'd2);
    cyc(0, 4'h0, 1, 1);
    check("idle_flush_none", 32'(out_valid), 32'd0);

    // nibble and flush together
    cyc(1, 4'h1, 0, 0);
    cyc(1, 4'h2, 1, 0);
    check("sim_word", 32'(out_word), 32'h0120);
    check("sim_cnt", 32'(out_cnt), 32'd2);
    cyc(0, 4'h0, 0, 1);
    cyc(1, 4'h7, 0, 1);
    cyc(1, 4'h8, 0, 1);
    cyc(1, 4'hF, 1, 0);
    check("simfull_word", 32'(out_word), 32'h078F);
    check("simfull_cnt", 32'(out_cnt), 32'd3);
    cyc(0, 4'h0, 0, 1);
    check("simfull_single", 32'(out_valid), 32'd0);

    // backpressure
    acc = 0;
    nxt = 1;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_nib = 4'(nxt); flush = 1'b0; out_ready = 1'b0;
      #1;
      if (in_ready) begin
        acc++;
        nxt++;
      end
      @(posedge clk);
      #2;
    end
    check("bp_accepts", 32'(acc), 32'd6);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("bp_full_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #2;
    check("bp_ready_back", 32'(in_ready), 32'd1);
    check("bp_second_word", 32'(out_word), 32'h0456);
    cyc(0, 4'h0, 0, 1);
    check("bp_drained", 32'(out_valid), 32'd0);

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      cyc(($urandom_range(0, 3) != 0), 4'($urandom), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 2) != 0));
    end
    rst_n = 1'b1;

    // word counter wrap, one word per cycle
    do_reset();
    for (int i = 0; i < 65537; i++) cyc(1, 4'($urandom), 1, 1);
    cyc(0, 4'h0, 0, 1);
    check("wrap_word_cnt", 32'(word_cnt), 32'd1);

    // reset mid-word discards the partial word
    cyc(1, 4'h3, 0, 1);
    cyc(1, 4'h4, 0, 1);
    rst_n = 1'b0;
    cyc(0, 4'h0, 0, 1);
    rst_n = 1'b1;
    cyc(1, 4'h5, 0, 1);
    cyc(0, 4'h0, 0, 1);
    check("midrst_no_word", 32'(out_valid), 32'd0);
    cyc(0, 4'h0, 1, 0);
    check("midrst_fresh_word", 32'(out_word), 32'h0500);
    check("midrst_fresh_cnt", 32'(out_cnt), 32'd1);
    cyc(0, 4'h0, 0, 1);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
